// File: rtl/matrix_cps_obi_mem.sv
// Banked multi-port OBI scratchpad for the matrix coprocessor.
// Words interleave across single-port banks; each bank picks one requesting
// channel per cycle round-robin, and every granted access answers exactly one
// cycle later through a registered response.

package matrix_cps_obi_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_resp_t;
endpackage

// Handshake: an access happens at the rising edge where req && gnt; the
// responder then drives rvalid for exactly one cycle after that edge. There is
// no rready, so a response can never be back-pressured.
module matrix_cps_obi_mem
    import matrix_cps_obi_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned BANK_DEPTH = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  obi_req_t  [NUM_CH-1:0] ch_req_i,
    output obi_resp_t [NUM_CH-1:0] ch_resp_o
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned ROW_W  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

    logic [31:0]        ch_word [NUM_CH];
    logic [BANK_W-1:0]  ch_bank [NUM_CH];
    logic [ROW_W-1:0]   ch_row  [NUM_CH];
    logic [NUM_CH-1:0]  unused_addr_lsb;

    logic [CH_W-1:0]    rr_q     [NUM_BANKS];
    logic [CH_W-1:0]    rr_d     [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_act;
    logic [NUM_BANKS-1:0] bank_go;
    logic [CH_W-1:0]    bank_win [NUM_BANKS];
    logic [NUM_CH-1:0]  ch_gnt;

    logic [ROW_W-1:0]   bank_row   [NUM_BANKS];
    logic               bank_we    [NUM_BANKS];
    logic [3:0]         bank_be    [NUM_BANKS];
    logic [31:0]        bank_wdata [NUM_BANKS];

    // Contents are deliberately not reset: the array is plain storage.
    logic [31:0]        mem_q [NUM_BANKS][BANK_DEPTH];

    logic [31:0]        rd_word [NUM_CH];
    logic [NUM_CH-1:0]  rvalid_q, rvalid_d;
    logic [31:0]        rdata_q [NUM_CH];
    logic [31:0]        rdata_d [NUM_CH];

    // Address decode: word index interleaves across banks, upper bits alias.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_word[c]         = {2'b00, ch_req_i[c].a.addr[31:2]};
            ch_bank[c]         = BANK_W'(ch_word[c] % NUM_BANKS);
            ch_row[c]          = ROW_W'((ch_word[c] / NUM_BANKS) % BANK_DEPTH);
            unused_addr_lsb[c] = ^ch_req_i[c].a.addr[1:0];
        end
    end

    // Per-bank round-robin: first requester at or after the bank's pointer wins.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx      = '0;
        bank_act = '0;
        ch_gnt   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_win[b] = '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                idx = CH_W'((32'(rr_q[b]) + k) % NUM_CH);
                if (!bank_act[b] && ch_req_i[idx].req && (ch_bank[idx] == BANK_W'(b))) begin
                    bank_act[b] = 1'b1;
                    bank_win[b] = idx;
                end
            end
            if (bank_act[b]) begin
                ch_gnt[bank_win[b]] = 1'b1;
            end
        end
    end

    // Pointer advances past the winner; idle banks keep their pointer.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            rr_d[b] = rr_q[b];
            if (bank_act[b]) begin
                rr_d[b] = CH_W'((32'(bank_win[b]) + 1) % NUM_CH);
            end
        end
    end

    // Route the winning channel's attributes to its bank; nothing commits in reset.
    always_comb begin
        bank_go = bank_act & {NUM_BANKS{rst_ni}};
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_row[b]   = ch_row[bank_win[b]];
            bank_we[b]    = ch_req_i[bank_win[b]].a.we;
            bank_be[b]    = ch_req_i[bank_win[b]].a.be;
            bank_wdata[b] = ch_req_i[bank_win[b]].a.wdata;
        end
    end

    // Round-robin pointer state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= rr_d[b];
        end
    end

    // Byte-masked bank writes; a zero mask still completes the handshake.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_go[b] && bank_we[b]) begin
                for (int i = 0; i < 4; i++) begin
                    if (bank_be[b][i]) begin
                        mem_q[b][bank_row[b]][8*i +: 8] <= bank_wdata[b][8*i +: 8];
                    end
                end
            end
        end
    end

    // Read data is the pre-edge word, so a same-edge write is not visible.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rd_word[c] = mem_q[ch_bank[c]][ch_row[c]];
            rdata_d[c] = (ch_gnt[c] && !ch_req_i[c].a.we) ? rd_word[c] : 32'h0;
        end
        rvalid_d = ch_gnt;
    end

    // Registered response; reset drops any in-flight rvalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            for (int c = 0; c < NUM_CH; c++) rdata_q[c] <= 32'h0;
        end else begin
            rvalid_q <= rvalid_d;
            for (int c = 0; c < NUM_CH; c++) rdata_q[c] <= rdata_d[c];
        end
    end

    // Drive the response ports; gnt is forced low while reset is asserted.
    always_comb begin
        ch_resp_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_resp_o[c].gnt     = ch_gnt[c] & rst_ni;
            ch_resp_o[c].rvalid  = rvalid_q[c];
            ch_resp_o[c].r.rdata = rdata_q[c];
        end
    end

endmodule
